// File: rtl/pid_pkg.sv
// Shared types and constants for the PID sequencer and its tick generator.
package pid_pkg;

  localparam int PID_D_WIDTH = 18;
  localparam int PID_N_COEF  = 4;

  localparam logic [1:0] PID_ADDR_COEF0 = 2'd0;
  localparam logic [1:0] PID_ADDR_COEF1 = 2'd1;
  localparam logic [1:0] PID_ADDR_COEF2 = 2'd2;
  localparam logic [1:0] PID_ADDR_COEF3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } pid_seq_state_t;

  // Maps a load beat onto the PID register it writes.
  function automatic logic [1:0] pid_coef_addr(input logic [1:0] beat);
    logic [1:0] addr;
    case (beat)
      2'd0:    addr = PID_ADDR_COEF0;
      2'd1:    addr = PID_ADDR_COEF1;
      2'd2:    addr = PID_ADDR_COEF2;
      default: addr = PID_ADDR_COEF3;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/pid_tick_gen.sv
// Iterate request source: sample-rate divider, or the external measurement strobe
// when sample_div is zero.
module pid_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] sample_div,
  input  logic                 meas_valid,
  input  logic                 freeze,
  input  logic                 clear,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic                 w_int_mode;
  logic                 w_hit;

  assign w_int_mode = |sample_div;
  // >= rather than == so a lowered divider never lets cnt run past it.
  assign w_hit      = r_cnt >= sample_div;
  assign tick       = w_int_mode ? w_hit : meas_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (!freeze && w_int_mode) begin
      r_cnt <= w_hit ? '0 : r_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pid_sequencer.sv
// Loads coefficient sets into one pid instance, sequences its reset, and
// issues iterate strobes once running.
//
// state | meaning
// IDLE  | no set loaded yet, pid held in reset, waiting for a set
// LOAD  | four write beats, one per coefficient register
// FLUSH | one-cycle pid reset after a load that asks for cleared state
// RUN   | iterating; a new handshake re-enters LOAD
module pid_sequencer
  import pid_pkg::*;
#(
  parameter int D_WIDTH    = PID_D_WIDTH,
  parameter int DIV_WIDTH  = 16,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic signed [D_WIDTH-1:0] cfg_coef0,
  input  logic signed [D_WIDTH-1:0] cfg_coef1,
  input  logic signed [D_WIDTH-1:0] cfg_coef2,
  input  logic signed [D_WIDTH-1:0] cfg_coef3,
  input  logic                  cfg_clear,
  input  logic [DIV_WIDTH-1:0]  sample_div,
  input  logic                  meas_valid,
  output logic                  pid_reset_n,
  output logic                  pid_write_enable,
  output logic [D_WIDTH-1:0]    pid_reg_addr,
  output logic [D_WIDTH-1:0]    pid_reg_data,
  output logic                  pid_iterate_enable,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_count
);

  pid_seq_state_t        r_state;
  logic [1:0]            r_beat;
  logic                  r_from_idle;
  logic                  r_clear;
  logic [D_WIDTH-1:0]    r_coef [PID_N_COEF];

  logic                  r_cfg_ready;
  logic                  r_rst_n;
  logic                  r_we_n;
  logic [D_WIDTH-1:0]    r_addr;
  logic [D_WIDTH-1:0]    r_data;
  logic                  r_iter;
  logic                  r_busy;
  logic [DROP_WIDTH-1:0] r_drop;

  logic [D_WIDTH-1:0]    w_cfg_coef [PID_N_COEF];
  logic                  w_handshake;
  logic                  w_busy_state;
  logic                  w_load_last;
  logic                  w_go_flush;
  logic                  w_run_entry;
  logic                  w_freeze;
  logic                  w_tick;
  logic [1:0]            w_next_beat;

  assign w_cfg_coef[0] = cfg_coef0;
  assign w_cfg_coef[1] = cfg_coef1;
  assign w_cfg_coef[2] = cfg_coef2;
  assign w_cfg_coef[3] = cfg_coef3;

  assign w_handshake  = cfg_valid && r_cfg_ready;
  assign w_busy_state = (r_state == ST_LOAD) || (r_state == ST_FLUSH);
  assign w_load_last  = (r_state == ST_LOAD) && (r_beat == 2'd3);
  // The first load after IDLE always flushes so the pid starts from clean state.
  assign w_go_flush   = r_clear || r_from_idle;
  assign w_run_entry  = (w_load_last && !w_go_flush) || (r_state == ST_FLUSH);
  assign w_freeze     = (r_state != ST_RUN);
  assign w_next_beat  = r_beat + 2'd1;

  pid_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .clock      (clock),
    .reset      (reset),
    .sample_div (sample_div),
    .meas_valid (meas_valid),
    .freeze     (w_freeze),
    .clear      (w_run_entry),
    .tick       (w_tick)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_beat      <= 2'd0;
      r_from_idle <= 1'b0;
      r_clear     <= 1'b0;
      for (int i = 0; i < PID_N_COEF; i++) r_coef[i] <= '0;
      r_cfg_ready <= 1'b1;
      r_rst_n     <= 1'b0;
      r_we_n      <= 1'b1;
      r_addr      <= '0;
      r_data      <= '0;
      r_iter      <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= '0;
    end else begin
      r_iter <= 1'b0;
      if (w_busy_state && w_tick && (r_drop != '1)) begin
        r_drop <= r_drop + DROP_WIDTH'(1);
      end
      unique case (r_state)
        ST_IDLE, ST_RUN: begin
          if (r_state == ST_RUN) r_iter <= w_tick;
          if (w_handshake) begin
            for (int i = 0; i < PID_N_COEF; i++) r_coef[i] <= w_cfg_coef[i];
            r_clear     <= cfg_clear;
            r_from_idle <= (r_state == ST_IDLE);
            r_state     <= ST_LOAD;
            r_beat      <= 2'd0;
            r_we_n      <= 1'b0;
            r_addr      <= D_WIDTH'(pid_coef_addr(2'd0));
            r_data      <= w_cfg_coef[0];
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (r_state == ST_IDLE) r_rst_n <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (!w_load_last) begin
            r_beat <= w_next_beat;
            r_addr <= D_WIDTH'(pid_coef_addr(w_next_beat));
            r_data <= r_coef[w_next_beat];
          end else begin
            r_we_n <= 1'b1;
            if (w_go_flush) begin
              r_state <= ST_FLUSH;
              r_rst_n <= 1'b0;
            end else begin
              r_state     <= ST_RUN;
              r_cfg_ready <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          r_state     <= ST_RUN;
          r_rst_n     <= 1'b1;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready          = r_cfg_ready;
  assign pid_reset_n        = r_rst_n;
  assign pid_write_enable   = r_we_n;
  assign pid_reg_addr       = r_addr;
  assign pid_reg_data       = r_data;
  assign pid_iterate_enable = r_iter;
  assign busy               = r_busy;
  assign drop_count         = r_drop;

endmodule
